// File: rtl/mul_seq_n_bit_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and the iteration counter width helper.
package mul_seq_n_bit_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_CALC = 2'd1,
        MUL_FIX  = 2'd2
    } mul_state_e;

    // Counter must be able to hold N itself.
    function automatic int mul_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mul_step_n_bit.sv
// One radix-2 shift-add iteration: conditionally accumulate the shifted
// multiplicand, then advance both operands by one bit position.
module mul_step_n_bit #(
    parameter int N = 32
) (
    input  logic [2*N-1:0] acc_i,
    input  logic [2*N-1:0] mcand_i,
    input  logic [N-1:0]   mplier_i,
    output logic [2*N-1:0] acc_o,
    output logic [2*N-1:0] mcand_o,
    output logic [N-1:0]   mplier_o
);

    assign acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
    assign mcand_o  = mcand_i << 1;
    assign mplier_o = mplier_i >> 1;

endmodule

// File: rtl/mul_seq_n_bit.sv
// Iterative signed/unsigned N-bit multiplier with start/busy/done handshake.
// Multiplies operand magnitudes over N cycles, then applies the sign in one fix cycle.
module mul_seq_n_bit
    import mul_seq_n_bit_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         Start,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    input  logic         Signed,
    output logic         Busy,
    output logic         Done,
    output logic [N-1:0] OutLo,
    output logic [N-1:0] OutHi,
    output logic         Ov
);

    localparam int CW = mul_cnt_w(N);

    mul_state_e     state_q;
    logic [2*N-1:0] acc_q, mcd_q;
    logic [N-1:0]   mpl_q;
    logic [CW-1:0]  cnt_q;
    logic           neg_q, sgn_q;
    logic           done_q, ov_q;
    logic [N-1:0]   lo_q, hi_q;

    logic [N-1:0]   xmag_d, ymag_d;
    logic [2*N-1:0] acc_d, mcd_d, prod_d;
    logic [N-1:0]   mpl_d;
    logic           ov_d;

    // Magnitude of -2^(N-1) wraps to 2^(N-1), which is the right unsigned value.
    assign xmag_d = (Signed && X[N-1]) ? -X : X;
    assign ymag_d = (Signed && Y[N-1]) ? -Y : Y;

    mul_step_n_bit #(.N(N)) u_step (
        .acc_i    (acc_q),
        .mcand_i  (mcd_q),
        .mplier_i (mpl_q),
        .acc_o    (acc_d),
        .mcand_o  (mcd_d),
        .mplier_o (mpl_d)
    );

    assign prod_d = neg_q ? -acc_q : acc_q;
    assign ov_d   = sgn_q ? (prod_d[2*N-1:N] != {N{prod_d[N-1]}})
                          : (prod_d[2*N-1:N] != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MUL_IDLE;
            acc_q   <= '0;
            mcd_q   <= '0;
            mpl_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            sgn_q   <= 1'b0;
            done_q  <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            ov_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MUL_IDLE: begin
                    if (Start) begin
                        acc_q   <= '0;
                        mcd_q   <= {{N{1'b0}}, xmag_d};
                        mpl_q   <= ymag_d;
                        cnt_q   <= '0;
                        neg_q   <= Signed & (X[N-1] ^ Y[N-1]);
                        sgn_q   <= Signed;
                        state_q <= MUL_CALC;
                    end
                end
                MUL_CALC: begin
                    acc_q <= acc_d;
                    mcd_q <= mcd_d;
                    mpl_q <= mpl_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1))
                        state_q <= MUL_FIX;
                end
                MUL_FIX: begin
                    lo_q    <= prod_d[N-1:0];
                    hi_q    <= prod_d[2*N-1:N];
                    ov_q    <= ov_d;
                    done_q  <= 1'b1;
                    state_q <= MUL_IDLE;
                end
                default: state_q <= MUL_IDLE;
            endcase
        end
    end

    assign Busy  = (state_q != MUL_IDLE);
    assign Done  = done_q;
    assign OutLo = lo_q;
    assign OutHi = hi_q;
    assign Ov    = ov_q;

endmodule

// File: tb/tb_mul_seq_n_bit.sv
// Self-checking bench for mul_seq_n_bit (N=32): directed corners, randomized
// operands against a 64-bit arithmetic reference, back-to-back issue and reset abort.
module tb_mul_seq_n_bit;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          Start = 1'b0;
    logic [N-1:0]  X = '0, Y = '0;
    logic          Signed = 1'b0;
    logic          Busy, Done, Ov;
    logic [N-1:0]  OutLo, OutHi;

    int vectors = 0;
    int errors  = 0;

    logic [63:0] exp_p;
    logic        exp_ov;

    mul_seq_n_bit #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Start  (Start),
        .X      (X),
        .Y      (Y),
        .Signed (Signed),
        .Busy   (Busy),
        .Done   (Done),
        .OutLo  (OutLo),
        .OutHi  (OutHi),
        .Ov     (Ov)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: full-width product and fit-in-N-bits test by value range.
    task automatic model(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint a, b, p;
        if (s) begin
            a = longint'($signed(x));
            b = longint'($signed(y));
            p = a * b;
            exp_ov = (p < -64'sd2147483648) || (p > 64'sd2147483647);
        end else begin
            a = longint'({32'd0, x});
            b = longint'({32'd0, y});
            p = a * b;
            exp_ov = (64'(p) > 64'h0000_0000_FFFF_FFFF);
        end
        exp_p = 64'(p);
    endtask

    // Called #1 after a clock edge; returns #1 after the Start-sampling edge
    // with inputs scrambled to show they are no longer needed.
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s);
        model(x, y, s);
        X = x; Y = y; Signed = s; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        X = $urandom; Y = $urandom; Signed = 1'($urandom);
    endtask

    // Waits for Done; lat/busy start at the given counts already elapsed.
    task automatic wait_done(input string tag, input int lat0, input int busy0);
        int lat, busy_cnt;
        bit seen;
        lat = lat0; busy_cnt = busy0; seen = 0;
        while (!seen && lat < 200) begin
            if (Busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
            if (Done) seen = 1;
        end
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        check({tag, " latency"},   64'(lat), 64'(N + 1));
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(N + 1));
        check({tag, " busy_in_done"}, 64'(Busy), 64'd0);
        check({tag, " product"}, {OutHi, OutLo}, exp_p);
        check({tag, " ov"}, 64'(Ov), 64'(exp_ov));
    endtask

    task automatic settle_after_done(input string tag);
        logic [63:0] p;
        p = exp_p;
        @(posedge clk); #1;
        check({tag, " done_width"}, 64'(Done), 64'd0);
        @(posedge clk); #1;
        check({tag, " hold"}, {OutHi, OutLo}, p);
    endtask

    initial begin
        #12;
        check("reset busy",  64'(Busy), 64'd0);
        check("reset done",  64'(Done), 64'd0);
        check("reset out",   {OutHi, OutLo}, 64'd0);
        check("reset ov",    64'(Ov), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        issue(32'd7, 32'd6, 1'b0);
        wait_done("u7x6", 0, 0);
        check("u7x6 lo", 64'(OutLo), 64'h2A);
        settle_after_done("u7x6");

        issue(32'hFFFF_FFFD, 32'd5, 1'b1);
        wait_done("s-3x5", 0, 0);
        check("s-3x5 lo", 64'(OutLo), 64'hFFFF_FFF1);
        check("s-3x5 hi", 64'(OutHi), 64'hFFFF_FFFF);
        settle_after_done("s-3x5");

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("umax", 0, 0);
        check("umax hi", 64'(OutHi), 64'hFFFF_FFFE);
        check("umax lo", 64'(OutLo), 64'h1);
        check("umax ov", 64'(Ov), 64'd1);
        settle_after_done("umax");

        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done("smin", 0, 0);
        check("smin hi", 64'(OutHi), 64'h0);
        check("smin lo", 64'(OutLo), 64'h8000_0000);
        check("smin ov", 64'(Ov), 64'd1);
        settle_after_done("smin");

        issue(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done("smin2", 0, 0);
        settle_after_done("smin2");

        issue(32'd0, 32'hDEAD_BEEF, 1'b1);
        wait_done("zero", 0, 0);
        settle_after_done("zero");

        // Start during CALC must be ignored; then a back-to-back issue from Done.
        issue(32'd12345, 32'd678, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        X = '0; Y = '0; Signed = 1'b0; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        wait_done("ignore", 5, 5);
        issue(32'd2, 32'd3, 1'b0);
        wait_done("b2b", 0, 0);
        check("b2b lo", 64'(OutLo), 64'd6);
        settle_after_done("b2b");

        for (int i = 0; i < 20; i++) begin
            logic [31:0] rx, ry;
            logic rs;
            rx = $urandom; ry = $urandom; rs = 1'($urandom);
            if (i % 5 == 0) rx = {rx[31], 31'(rx[7:0])};
            issue(rx, ry, rs);
            wait_done($sformatf("rand%0d", i), 0, 0);
            if (i % 4 == 0) settle_after_done($sformatf("rand%0d", i));
        end

        // Asynchronous reset mid-CALC: outputs clear without an edge.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst busy", 64'(Busy), 64'd0);
        check("arst done", 64'(Done), 64'd0);
        check("arst out",  {OutHi, OutLo}, 64'd0);
        check("arst ov",   64'(Ov), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        begin
            int dones;
            dones = 0;
            repeat (N + 6) begin
                @(posedge clk); #1;
                if (Done || Busy) dones++;
            end
            check("arst no_done", 64'(dones), 64'd0);
        end
        issue(32'hFFFF_FF9C, 32'd100, 1'b1);
        wait_done("post_rst", 0, 0);
        settle_after_done("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_seq_n_bit.md
Name: mul_seq_n_bit

Overview:
- Iterative N-bit integer multiplier, signed or unsigned; the multiply counterpart to the combinational divide unit in the CPU datapath.
- Uses a radix-2 shift-add algorithm on operand magnitudes: N calculate cycles plus one sign-fix cycle.
- Handshake is start/busy/done, so the control unit can stall on MUL/MULH instructions.
- Returns the full 2N-bit product plus an overflow flag for N-bit truncation.

Parameters:
- N, 32, operand width in bits. Must be at least 4.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Start  in  1  request; sampled only when Busy=0
- X  in  N  multiplicand; sampled with Start
- Y  in  N  multiplier; sampled with Start
- Signed  in  1  1 = both operands are two's complement; sampled with Start
- Busy  out  1  high while an operation is in flight
- Done  out  1  one-cycle pulse; OutLo/OutHi/Ov are valid from this cycle on
- OutLo  out  N  product bits [N-1:0]
- OutHi  out  N  product bits [2N-1:N]
- Ov  out  1  product does not fit in N bits (signed or unsigned sense per latched Signed)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, Busy=0, Done=0, OutLo=0, OutHi=0, Ov=0, internal regs=0. Reset mid-operation aborts it; no Done pulse follows.
- States: IDLE, CALC, FIX.
- IDLE:
  - Busy=0.
  - Start=1 at clock edge E0: latch the magnitudes |X| and |Y| (the absolute values when Signed=1, the raw bits otherwise), latch neg = Signed & (X[N-1]^Y[N-1]), latch Signed, clear the 2N-bit accumulator, set count=0, go to CALC.
  - |-2^(N-1)| = 2^(N-1) is representable as an N-bit unsigned magnitude.
- CALC:
  - Busy=1.
  - Each edge: if the multiplier LSB is 1, add the shifted multiplicand into the accumulator; then shift the multiplicand left and the multiplier right; count++.
  - Leaves to FIX at the edge where count reaches N (edge EN).
- FIX:
  - Busy=1.
  - At edge EN+1: product P = neg ? two's-complement negate of accumulator (2N bits) : accumulator.
  - OutLo=P[N-1:0], OutHi=P[2N-1:N].
  - Ov = Signed ? (OutHi != {N{OutLo[N-1]}}) : (OutHi != 0).
  - Done=1, next state IDLE.
- Latency: Done is high in the cycle after edge EN+1, i.e. N+1 edges after the Start-sampling edge. Exactly one cycle wide.
- Done cycle is an IDLE cycle (Busy=0). A Start there is accepted, so back-to-back issue has a throughput of N+2 cycles.
- Start while Busy=1 is ignored entirely; no queuing, no effect on the in-flight operation.
- X, Y and Signed may change freely after the Start edge.
- OutLo, OutHi and Ov hold their values until the next Done or reset.
- Zero operands get no early termination; latency is data-independent.
- Arithmetic: all additions are 2N bits wide and modulo 2^2N. The count register is clog2(N+1) bits.

Decomposition:
- Shared package/include mul_defs:
  - state encoding localparams MUL_IDLE=2'd0, MUL_CALC=2'd1, MUL_FIX=2'd2
  - macro for the count width clog2(N+1)
- One natural sub-module, mul_step_n_bit: combinational single add-shift iteration. Inputs are the accumulator, shifted multiplicand and multiplier; outputs are their next values. Instantiated once in CALC.
- The FSM, latching and sign fix stay in the top.

Test Plan:
- Unsigned 7*6 (N=32): Start with Signed=0 -> Done exactly 33 edges after the Start edge, OutLo=0x0000002A, OutHi=0, Ov=0, Busy high for 33 cycles.
- Signed -3*5: X=0xFFFFFFFD, Y=5, Signed=1 -> OutLo=0xFFFFFFF1, OutHi=0xFFFFFFFF, Ov=0.
- Unsigned max*max: X=Y=0xFFFFFFFF, Signed=0 -> OutHi=0xFFFFFFFE, OutLo=0x00000001, Ov=1.
- Signed min*-1: X=0x80000000, Y=0xFFFFFFFF, Signed=1 -> OutHi=0x00000000, OutLo=0x80000000, Ov=1.
- Start pulsed mid-CALC with X=Y=0, then Start again in the Done cycle with 2*3 -> first result unaffected, second Done N+1 edges later with OutLo=6.
- Assert rst_n=0 during CALC -> Busy/Done/OutLo/OutHi/Ov go to 0 immediately (asynchronously) and no Done pulse appears afterwards. A new Start after release completes normally.
